// File: rtl/bram_stall_ctrl.sv
// Issue gate: stalls an instruction until every BRAM-served source operand has delivered data.
// Optional sticky stall-timeout error flag enabled by defining BRAM_STALL_TIMEOUT_EN.

`ifndef NAMESPACE_DATA
`define NAMESPACE_DATA 1
`endif
`ifndef NAMESPACE_WEIGHT
`define NAMESPACE_WEIGHT 2
`endif
`ifndef NAMESPACE_GRADIENT
`define NAMESPACE_GRADIENT 3
`endif
`ifndef NAMESPACE_META
`define NAMESPACE_META 4
`endif

module bram_stall_ctrl #(
  parameter int                    SRC_NUM        = 3,
  parameter int                    NS_W           = 3,
  parameter logic [(1<<NS_W)-1:0]  BRAM_NS_MASK   = (1<<NS_W)'((1 << `NAMESPACE_DATA)
                                                    | (1 << `NAMESPACE_WEIGHT)
                                                    | (1 << `NAMESPACE_GRADIENT)
                                                    | (1 << `NAMESPACE_META)),
  parameter int                    CNT_W          = 8,
  parameter int                    TIMEOUT_CYCLES = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [(1<<NS_W)-1:0]          ns_out_v,
  input  logic [SRC_NUM*(1<<NS_W)-1:0]  src_decoder_out,
  input  logic                          inst_valid,
  input  logic                          timeout_clr,
  output logic [SRC_NUM-1:0]            src_v_bram,
  output logic                          inst_stall_bram,
  output logic                          inst_fire,
  output logic [CNT_W-1:0]              stall_cycles,
  output logic                          stall_timeout
);

  localparam int NS_NUM = 1 << NS_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SRC_NUM-1:0]   got_q, got_d;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic [SRC_NUM-1:0]   req, hit, got_eff;
  logic [NS_NUM-1:0]    slice;
  logic                 inst_done;

  // got is masked during reset so outputs reflect the post-reset view immediately
  always_comb begin
    req        = '0;
    hit        = '0;
    slice      = '0;
    got_eff    = reset ? '0 : got_q;
    src_v_bram = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      slice         = src_decoder_out[i*NS_NUM +: NS_NUM];
      req[i]        = |(slice & BRAM_NS_MASK);
      hit[i]        = (|(slice & BRAM_NS_MASK & ns_out_v)) & inst_valid;
      src_v_bram[i] = (hit[i] | got_eff[i]) & inst_valid;
    end
    inst_stall_bram = inst_valid & (|(req & ~src_v_bram));
    inst_fire       = inst_valid & ~inst_stall_bram;
    inst_done       = inst_fire | ~inst_valid;
  end

  always_comb begin
    state_d        = state_q;
    got_d          = got_q | hit;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      IDLE:    if (inst_stall_bram) state_d = WAIT;
      WAIT:    if (inst_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Retiring or dropping the instruction wipes the collected operand state
    if (inst_done) begin
      got_d          = '0;
      stall_cycles_d = '0;
    end else if (inst_stall_bram && stall_cycles_q != CNT_MAX) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      got_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      got_q          <= got_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

`ifdef BRAM_STALL_TIMEOUT_EN
  logic timeout_q, timeout_d;

  // A fresh set wins over a same-cycle clear
  always_comb begin
    timeout_d = timeout_q & ~timeout_clr;
    if (inst_stall_bram && stall_cycles_q == CNT_W'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  assign stall_timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_clr ^ (TIMEOUT_CYCLES == 0);
  assign stall_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_bram_stall_ctrl.sv
// Randomized bench for bram_stall_ctrl against a per-instruction operand-arrival model.
`ifndef NAMESPACE_DATA
`define NAMESPACE_DATA 1
`endif
`ifndef NAMESPACE_WEIGHT
`define NAMESPACE_WEIGHT 2
`endif
`ifndef NAMESPACE_GRADIENT
`define NAMESPACE_GRADIENT 3
`endif
`ifndef NAMESPACE_META
`define NAMESPACE_META 4
`endif

module tb_bram_stall_ctrl;
  localparam int SRC = 3;
  localparam int NSN = 8;
  localparam int MAX_A = 255;
  localparam int MAX_B = 15;
  localparam int TO_A = 200;
  localparam int TO_B = 5;
`ifdef BRAM_STALL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, inst_valid, timeout_clr;
  logic [NSN-1:0]   ns_out_v;
  logic [SRC*NSN-1:0] dec;
  logic [SRC-1:0]   srcv_a, srcv_b;
  logic             stall_a, stall_b, fire_a, fire_b, tmo_a, tmo_b;
  logic [7:0]       cyc_a;
  logic [3:0]       cyc_b;

  bram_stall_ctrl dut_a (
    .clk(clk), .reset(reset), .ns_out_v(ns_out_v), .src_decoder_out(dec),
    .inst_valid(inst_valid), .timeout_clr(timeout_clr), .src_v_bram(srcv_a),
    .inst_stall_bram(stall_a), .inst_fire(fire_a), .stall_cycles(cyc_a),
    .stall_timeout(tmo_a)
  );

  bram_stall_ctrl #(.CNT_W(4), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .reset(reset), .ns_out_v(ns_out_v), .src_decoder_out(dec),
    .inst_valid(inst_valid), .timeout_clr(timeout_clr), .src_v_bram(srcv_b),
    .inst_stall_bram(stall_b), .inst_fire(fire_b), .stall_cycles(cyc_b),
    .stall_timeout(tmo_b)
  );

  int checks = 0;
  int failures = 0;
  int src_ns[SRC];
  bit mgot[SRC];
  int mcnt_a, mcnt_b;
  bit mtmo_a, mtmo_b;

  localparam logic [NSN-1:0] V_DATA   = NSN'(1 << `NAMESPACE_DATA);
  localparam logic [NSN-1:0] V_WEIGHT = NSN'(1 << `NAMESPACE_WEIGHT);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_bram(input int ns);
    return ns == `NAMESPACE_DATA || ns == `NAMESPACE_WEIGHT ||
           ns == `NAMESPACE_GRADIENT || ns == `NAMESPACE_META;
  endfunction

  task automatic set_instr(input int s0, input int s1, input int s2);
    src_ns[0] = s0; src_ns[1] = s1; src_ns[2] = s2;
    dec = '0;
    for (int i = 0; i < SRC; i++)
      if (src_ns[i] >= 0) dec[i*NSN + src_ns[i]] = 1'b1;
  endtask

  task automatic drv(input bit rst, input bit iv, input logic [NSN-1:0] nsv, input bit clr);
    reset = rst; inst_valid = iv; ns_out_v = nsv; timeout_clr = clr;
    #2;
  endtask

  // Compare this cycle's outputs against the model, advance the model, move to next negedge
  task automatic step(output bit fired);
    bit arrived[SRC];
    bit need, avail, stall, fire;
    logic [SRC-1:0] exp_v;
    stall = 1'b0;
    exp_v = '0;
    for (int i = 0; i < SRC; i++) begin
      need       = src_ns[i] >= 0 && is_bram(src_ns[i]);
      arrived[i] = need && inst_valid && ns_out_v[src_ns[i]];
      avail      = inst_valid && (arrived[i] || (mgot[i] && !reset));
      exp_v[i]   = avail;
      if (inst_valid && need && !avail) stall = 1'b1;
    end
    fire = inst_valid && !stall;
    check("src_v_a", 32'(srcv_a), 32'(exp_v));
    check("src_v_b", 32'(srcv_b), 32'(exp_v));
    check("stall_a", 32'(stall_a), 32'(stall));
    check("stall_b", 32'(stall_b), 32'(stall));
    check("fire_a", 32'(fire_a), 32'(fire));
    check("fire_b", 32'(fire_b), 32'(fire));
    check("cycles_a", 32'(cyc_a), 32'(mcnt_a));
    check("cycles_b", 32'(cyc_b), 32'(mcnt_b));
    check("timeout_a", 32'(tmo_a), 32'(mtmo_a));
    check("timeout_b", 32'(tmo_b), 32'(mtmo_b));
    if (reset) begin
      for (int i = 0; i < SRC; i++) mgot[i] = 1'b0;
      mcnt_a = 0; mcnt_b = 0; mtmo_a = 1'b0; mtmo_b = 1'b0;
    end else begin
      mtmo_a = TMO_EN && ((stall && mcnt_a == TO_A) || (mtmo_a && !timeout_clr));
      mtmo_b = TMO_EN && ((stall && mcnt_b == TO_B) || (mtmo_b && !timeout_clr));
      if (!inst_valid || fire) begin
        for (int i = 0; i < SRC; i++) mgot[i] = 1'b0;
        mcnt_a = 0; mcnt_b = 0;
      end else begin
        for (int i = 0; i < SRC; i++) if (arrived[i]) mgot[i] = 1'b1;
        if (stall) begin
          mcnt_a = (mcnt_a < MAX_A) ? mcnt_a + 1 : MAX_A;
          mcnt_b = (mcnt_b < MAX_B) ? mcnt_b + 1 : MAX_B;
        end
      end
    end
    fired = fire;
    @(negedge clk);
  endtask

  initial begin
    bit f;
    bit pending;
    int starve;
    logic [NSN-1:0] nsv;
    for (int i = 0; i < SRC; i++) mgot[i] = 1'b0;
    mcnt_a = 0; mcnt_b = 0; mtmo_a = 1'b0; mtmo_b = 1'b0;
    set_instr(-1, -1, -1);
    reset = 1'b1; inst_valid = 1'b0; ns_out_v = '0; timeout_clr = 1'b0;
    @(negedge clk);
    drv(1, 0, '0, 0);
    check("reset_cycles", 32'(cyc_a), 32'd0);
    step(f);

    // Both BRAM operands present: zero-latency issue
    set_instr(`NAMESPACE_DATA, `NAMESPACE_WEIGHT, 0);
    drv(0, 1, V_DATA | V_WEIGHT, 0);
    check("r031_fire", 32'(fire_a), 32'd1);
    step(f);
    drv(0, 0, '0, 0);
    check("r031_cycles", 32'(cyc_a), 32'd0);
    step(f);

    // Data early, weight three cycles later
    drv(0, 1, V_DATA, 0);
    check("r032_stall0", 32'(stall_a), 32'd1);
    step(f);
    drv(0, 1, '0, 0);
    check("r032_got1", 32'(srcv_a), 32'b001);
    step(f);
    drv(0, 1, '0, 0); step(f);
    drv(0, 1, V_WEIGHT, 0);
    check("r032_fire3", 32'(fire_a), 32'd1);
    check("r032_cycles3", 32'(cyc_a), 32'd3);
    step(f);
    drv(0, 1, '0, 0);
    check("r032_clear4", 32'(srcv_a), 32'd0);
    check("r032_cnt4", 32'(cyc_a), 32'd0);
    step(f);
    drv(0, 0, '0, 0); step(f);

    // Abort after two stall cycles, then fresh instruction issues at once
    drv(0, 1, V_DATA, 0); step(f);
    drv(0, 1, '0, 0); step(f);
    drv(0, 0, '0, 0); step(f);
    drv(0, 1, V_DATA | V_WEIGHT, 0);
    check("r033_fire", 32'(fire_a), 32'd1);
    check("r033_cycles", 32'(cyc_a), 32'd0);
    step(f);

    // Long starvation: narrow counter saturates, timeout behaviour
    drv(0, 1, V_DATA, 0); step(f);
    for (int k = 0; k < 20; k++) begin
      drv(0, 1, '0, 0); step(f);
    end
    drv(0, 1, V_WEIGHT, 0);
    check("r034_sat", 32'(cyc_b), 32'd15);
    check("r034_wide", 32'(cyc_a), 32'd21);
    step(f);
    drv(0, 0, '0, 0);
    check("r035_hold", 32'(tmo_b), 32'(TMO_EN));
    step(f);
    drv(0, 0, '0, 1); step(f);
    drv(0, 0, '0, 0);
    check("r035_clr", 32'(tmo_b), 32'd0);
    step(f);

    // Reset in the middle of a stall with got[0] set
    drv(0, 1, V_DATA, 0); step(f);
    drv(0, 1, '0, 0);
    check("r036_got", 32'(srcv_a), 32'b001);
    step(f);
    drv(1, 1, '0, 0);
    check("r036_rst_mask", 32'(srcv_a), 32'd0);
    step(f);
    drv(0, 1, '0, 0);
    check("r036_cnt", 32'(cyc_a), 32'd0);
    check("r036_got0", 32'(srcv_a), 32'd0);
    step(f);
    drv(0, 0, '0, 0); step(f);

    // Randomized instruction stream
    pending = 1'b0;
    starve = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!pending) begin
        set_instr(int'($urandom_range(0, 8)) - 1, int'($urandom_range(0, 8)) - 1,
                  int'($urandom_range(0, 8)) - 1);
        pending = ($urandom_range(0, 9) != 0);
        starve  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : 0;
      end
      nsv = (starve > 0) ? '0 : NSN'($urandom & $urandom);
      if (starve > 0) starve--;
      if (pending && $urandom_range(0, 29) == 0) pending = 1'b0;
      drv($urandom_range(0, 99) == 0, pending, nsv, $urandom_range(0, 9) == 0);
      step(f);
      if (f || reset || !inst_valid) pending = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bram_stall_ctrl.md
BRAM_STALL_CTRL -- requirements
Module: bram_stall_ctrl

Interface
REQ-001 Parameter SRC_NUM, default 3: number of instruction source operands.
REQ-002 Parameter NS_W, default 3: namespace-select width; NS_NUM = 1 << NS_W one-hot namespaces per source.
REQ-003 Parameter BRAM_NS_MASK, NS_NUM bits, default bits `NAMESPACE_DATA, `NAMESPACE_WEIGHT, `NAMESPACE_GRADIENT, `NAMESPACE_META set: namespaces served by BRAM.
REQ-004 Parameter CNT_W, default 8: stall-cycle counter width.
REQ-005 Parameter TIMEOUT_CYCLES, default 200: stall length that flags a timeout (must be < 2^CNT_W).
REQ-006 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port ns_out_v, input, NS_NUM: per-namespace BRAM read-data valid.
REQ-009 Port src_decoder_out, input, SRC_NUM*NS_NUM: one-hot namespace decode per source; source i occupies bits [i*NS_NUM +: NS_NUM].
REQ-010 Port inst_valid, input, 1: current instruction valid.
REQ-011 Port timeout_clr, input, 1: clears stall_timeout.
REQ-012 Port src_v_bram, output, SRC_NUM: per-source BRAM operand available.
REQ-013 Port inst_stall_bram, output, 1: instruction must stall for BRAM operands.
REQ-014 Port inst_fire, output, 1: one-cycle pulse; instruction issues this cycle.
REQ-015 Port stall_cycles, output, CNT_W: cycles spent in current stall.
REQ-016 Port stall_timeout, output, 1: sticky stall-timeout error.

Function
REQ-017 req[i] SHALL be OR of (src_decoder_out slice i AND BRAM_NS_MASK); hit[i] SHALL be OR of (slice i AND BRAM_NS_MASK AND ns_out_v) AND inst_valid.
REQ-018 Per-source sticky register got[i] SHALL set on hit[i], so data valid in an earlier stall cycle is not lost when its namespace valid drops.
REQ-019 src_v_bram[i] SHALL equal (hit[i] OR got[i]) AND inst_valid, combinationally.
REQ-020 inst_stall_bram SHALL equal inst_valid AND OR over i of (req[i] AND NOT src_v_bram[i]); no stall when inst_valid is low.
REQ-021 inst_fire SHALL equal inst_valid AND NOT inst_stall_bram; an instruction with no BRAM source fires same cycle (zero latency).
REQ-022 FSM states IDLE and WAIT; IDLE->WAIT when inst_stall_bram; WAIT->IDLE on inst_fire or inst_valid low; else hold.
REQ-023 All got[i] SHALL clear on the cycle after inst_fire or after inst_valid low (abort); clear has priority over set in the same cycle.
REQ-024 stall_cycles SHALL increment by 1 on each cycle inst_stall_bram is high, saturate at 2^CNT_W-1, and clear to 0 on the cycle after inst_fire or inst_valid low.
REQ-025 Upstream SHALL hold src_decoder_out constant from first stall cycle until inst_fire or inst_valid low; block behaviour otherwise is undefined.
REQ-026 Simultaneous namespace valids for several sources SHALL set all matching got bits in the same cycle.

Reset
REQ-027 On reset: FSM=IDLE, got=0, stall_cycles=0, stall_timeout=0; reset overrides all other updates that cycle.
REQ-028 Combinational outputs SHALL follow REQ-019..021 with got=0 during reset.

Configuration
REQ-029 Macro BRAM_STALL_TIMEOUT_EN defined: stall_timeout SHALL set when stall_cycles equals TIMEOUT_CYCLES while stalled, hold until timeout_clr or reset; timeout_clr and set in same cycle leaves it set.
REQ-030 Macro undefined: stall_timeout SHALL be constant 0, timeout_clr ignored; ports remain present.

Verification
REQ-031 src0=DATA, src1=WEIGHT, src2 non-BRAM, inst_valid=1, data_v and weight_v high -> inst_fire=1 same cycle, stall_cycles stays 0.
REQ-032 Same instruction, data_v high cycle 0 only, weight_v high cycle 3 only -> stall cycles 0-2, got[0] set from cycle 1, inst_fire at cycle 3, got cleared cycle 4.
REQ-033 Stall 2 cycles then inst_valid low -> no fire, got and stall_cycles 0 next cycle; new instruction with fresh data_v fires immediately.
REQ-034 CNT_W=4, weight_v never asserted for 20 cycles -> stall_cycles saturates at 15.
REQ-035 BRAM_STALL_TIMEOUT_EN, TIMEOUT_CYCLES=5 -> stall_timeout rises when stall_cycles=5, holds after fire, clears on timeout_clr; without macro stays 0.
REQ-036 Reset asserted mid-stall with got[0]=1 -> next cycle FSM IDLE, got=0, stall_cycles=0, stall_timeout=0.
